instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage placed directly upstream of the memory block. It owns the program counter and drives the memory PC input. It captures the 32-bit instruction returned by the combinational instruction_memory read. It buffers {pc, instruction} pairs in a small FIFO, and decode consumes them through a valid/ready handshake. It supports pipeline redirects (branch/jump), which flush in-flight entries.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
DEPTH, 2, fetch buffer entries; power of two, 2..8
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
PC  output  32  fetch address driven to the memory PC input
instruction  input  32  instruction word returned by memory for the current PC (same cycle, combinational)
redirect_valid  input  1  redirect request from execute (taken branch/jump)
redirect_pc  input  32  redirect target address
fetch_en  input  1  global run enable; 0 freezes fetching without losing buffered entries
out_valid  output  1  head entry available to decode
out_ready  input  1  decode accepts head entry this cycle
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry
fetched_count  output  32  number of instructions pushed since reset; wraps modulo 2^32

Behaviour:
- Reset (rst_n=0 at a clk edge): PC_reg<=PC_RESET, buffer emptied (count=0, read and write pointers 0), fetched_count<=0.
- Outputs after reset: out_valid=0, out_pc=0, out_instr=0 (empty buffer outputs forced to 0), PC=PC_RESET.
- Reset has priority over every other input, including during an active redirect or a full buffer.
- PC output equals PC_reg combinationally; instruction is sampled in the same cycle.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
  - Simultaneous push and pop on a full buffer is legal; count is unchanged.
- On push: write {PC_reg, instruction} at the write pointer, PC_reg <= PC_reg + PC_STEP (32-bit wrap, 32'hFFFF_FFFC -> 0), fetched_count += 1.
- No push: PC_reg holds.
- Redirect (redirect_valid=1), highest priority after reset:
  - Buffer flushed: count<=0, pointers<=0.
  - PC_reg <= {redirect_pc[31:2], 2'b00}; low bits are silently forced to 0.
  - No push that cycle.
  - A pop that cycle is ignored: out_valid still shows the old head, but decode must treat its own redirect as a kill.
  - The first instruction from the target is visible on out_valid the cycle after the redirect, provided fetch_en=1.
- Back-to-back redirects: each one overrides the previous one; only the last target is fetched.
- Latency:
  - Empty buffer, fetch_en=1, out_ready=1: the instruction at PC_reg appears on out_* one cycle after the push.
  - Sustained throughput is 1 instruction/cycle.
- Full buffer with out_ready=0: PC holds and outputs are stable until a pop occurs. Handshake rule: out_pc/out_instr must not change while out_valid=1 and out_ready=0, except on redirect or reset.
- fetch_en=0: no push; pops continue, so the buffer drains.
- Internal state machine, two states:
  - RUN: fetch_en=1.
  - HOLD: fetch_en=0.
  - Transitions: RUN->HOLD on fetch_en=0; HOLD->RUN on fetch_en=1.
  - A redirect is accepted in either state. A redirect taken in HOLD updates PC_reg, and fetching resumes from the new PC on return to RUN.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN_INST=32 and the PC width.
  - PC_STEP and PC_RESET defaults.
  - The fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - The fetch_state_t enum {RUN, HOLD}.
- One sub-module is natural: fetch_fifo, a parameterised DEPTH-entry synchronous FIFO.
  - Ports: push, pop, flush, data in/out, count, full, empty.
  - instruction_fetch instantiates it and keeps the PC, redirect and counter logic at top level.

Test Plan:
- Reset then fetch_en=1, out_ready=1, memory returning instr=PC^32'hA5A5_0000 -> PC sequence 0,4,8,12; out_pc=0 at cycle 1, one entry per cycle; fetched_count=4 after 4 pushes.
- out_ready=0 for 5 cycles from empty -> buffer fills at 2 entries, PC stalls at 8, out_pc=0 held stable; releasing out_ready -> out_pc 0,4,8 consecutively with no gap.
- Redirect while full, redirect_pc=32'h0000_0103 -> buffer empties, PC=32'h100 next cycle, next out_pc=32'h100, old entries 0 and 4 never accepted.
- Simultaneous push+pop on full buffer for 10 cycles -> count stays 2, out_pc increments by 4 each cycle.
- PC_RESET=32'hFFFF_FFF8, free-run -> PC FFFF_FFF8, FFFF_FFFC, 0000_0000; no stall at wrap.
- rst_n=0 asserted mid-redirect with a full buffer -> next cycle out_valid=0, PC=PC_RESET, fetched_count=0; rst_n=0 without a clk edge has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and defaults: instruction/PC widths, fetch buffer entry, fetch FSM states.
package cpu_pkg;

    localparam int XLEN_INST = 32;
    localparam int PC_W      = 32;

    localparam logic [PC_W-1:0] PC_STEP_DEF  = 32'd4;
    localparam logic [PC_W-1:0] PC_RESET_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [XLEN_INST-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push has written it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, captures the memory word for that PC and hands {pc, instr} to decode.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_W-1:0]      PC,
    input  logic [XLEN_INST-1:0] instruction,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 fetch_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [XLEN_INST-1:0] out_instr,
    output logic [31:0]          fetched_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     fetched_count_q, fetched_count_d;

    logic         pop, push, fifo_pop;
    logic         fifo_full, fifo_empty;
    logic [AW:0]  fifo_count;
    fetch_entry_t wr_entry, rd_entry;

    assign pop      = out_valid & out_ready;
    assign push     = fetch_en & ~redirect_valid & (~fifo_full | pop);
    // The redirect flush wins; decode kills the head it sees in that cycle itself.
    assign fifo_pop = pop & ~redirect_valid;

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = instruction;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!fetch_en) state_d = HOLD;
            HOLD:    if (fetch_en)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d            = pc_q;
        fetched_count_d = fetched_count_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (push) begin
            pc_d            = pc_q + PC_STEP;
            fetched_count_d = fetched_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RUN;
            pc_q            <= PC_RESET;
            fetched_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            fetched_count_q <= fetched_count_d;
        end
    end

    assign PC            = pc_q;
    assign out_valid     = ~fifo_empty;
    assign out_pc        = rd_entry.pc;
    assign out_instr     = rd_entry.instr;
    assign fetched_count = fetched_count_q;

endmodule
